// File: rtl/pulse_counter_sched.sv
// Round-robin scheduler that time-shares one pulse counter between N requesters.
// Optional wrap counting is enabled by defining PULSE_COUNTER_SCHED_WRAP_COUNT_EN.
module pulse_counter_sched #(
   parameter int unsigned N          = 4,
   parameter int unsigned LEN_W      = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX        = 20,
   localparam int unsigned IDW       = (N > 1) ? $clog2(N) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N-1:0]            req,
   input  logic [N*LEN_W-1:0]      req_len,
   input  logic                    abort,
   output logic [N-1:0]            gnt,
   output logic                    busy,
   output logic                    cnt_reset,
   output logic                    cnt_start,
   output logic                    cnt_stop,
   input  logic [DATA_WIDTH-1:0]   cnt_count,
   output logic                    done,
   output logic [IDW-1:0]          done_id,
   output logic [DATA_WIDTH-1:0]   result,
   output logic                    aborted,
   output logic [7:0]              wrap_cnt
);

   if (N < 2 || N > 16 || MAX > (2 ** DATA_WIDTH) - 1) begin : g_param_check
      $error("pulse_counter_sched: unsupported parameter combination");
   end

   typedef enum logic [1:0] {StIdle, StClr, StRun, StStop} state_e;

   state_e                 state_q, state_d;
   logic [N-1:0]           gnt_q, gnt_d;
   logic [IDW-1:0]         ptr_q, ptr_d;
   logic [IDW-1:0]         id_q, id_d;
   logic [LEN_W-1:0]       len_q, len_d;
   logic [LEN_W-1:0]       run_q, run_d;
   logic                   abort_seen_q, abort_seen_d;
   logic                   done_q;
   logic [IDW-1:0]         done_id_q;
   logic [DATA_WIDTH-1:0]  result_q;
   logic                   aborted_q;

   logic [IDW-1:0]         pick;
   logic [IDW-1:0]         cand;
   logic                   found;

   // First pending requester at or above the pointer, wrapping modulo N.
   always_comb begin
      pick  = '0;
      cand  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = IDW'((32'(ptr_q) + i) % N);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      ptr_d        = ptr_q;
      id_d         = id_q;
      len_d        = len_q;
      run_d        = run_q;
      abort_seen_d = abort_seen_q;
      cnt_reset    = 1'b0;
      cnt_start    = 1'b0;
      cnt_stop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               gnt_d        = '0;
               gnt_d[pick]  = 1'b1;
               id_d         = pick;
               len_d        = req_len[pick*LEN_W +: LEN_W];
               ptr_d        = (pick == IDW'(N - 1)) ? '0 : pick + 1'b1;
               run_d        = LEN_W'(1);
               abort_seen_d = 1'b0;
               state_d      = StClr;
            end
         end
         StClr: begin
            cnt_reset = 1'b1;
            state_d   = (len_q == '0) ? StStop : StRun;
         end
         StRun: begin
            // An abort on the first cycle must not also start the counter.
            cnt_start = (run_q == LEN_W'(1)) && !abort;
            if (abort) begin
               cnt_stop     = 1'b1;
               abort_seen_d = 1'b1;
               state_d      = StStop;
            end else if (run_q == len_q) begin
               state_d = StStop;
            end else begin
               run_d = run_q + 1'b1;
            end
         end
         StStop: begin
            cnt_stop = 1'b1;
            gnt_d    = '0;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         gnt_q        <= '0;
         ptr_q        <= '0;
         id_q         <= '0;
         len_q        <= '0;
         run_q        <= '0;
         abort_seen_q <= 1'b0;
         done_q       <= 1'b0;
         done_id_q    <= '0;
         result_q     <= '0;
         aborted_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         ptr_q        <= ptr_d;
         id_q         <= id_d;
         len_q        <= len_d;
         run_q        <= run_d;
         abort_seen_q <= abort_seen_d;
         done_q       <= (state_q == StStop);
         if (state_q == StStop) begin
            result_q  <= cnt_count;
            done_id_q <= id_q;
            aborted_q <= abort_seen_q;
         end
      end
   end

`ifdef PULSE_COUNTER_SCHED_WRAP_COUNT_EN
   logic [7:0]            wraps_q, wraps_d;
   logic [7:0]            wrap_cnt_q;
   logic [DATA_WIDTH-1:0] prev_q;

   // A drop in the counter value between consecutive cycles marks a MAX->0 wrap.
   always_comb begin
      wraps_d = wraps_q;
      if (state_q == StClr) begin
         wraps_d = '0;
      end else if ((state_q == StRun || state_q == StStop) && cnt_count < prev_q &&
                   wraps_q != 8'hff) begin
         wraps_d = wraps_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wraps_q    <= '0;
         wrap_cnt_q <= '0;
         prev_q     <= '0;
      end else begin
         wraps_q <= wraps_d;
         // The counter is cleared at the CLR edge, so the reference restarts at zero.
         prev_q  <= (state_q == StClr) ? '0 : cnt_count;
         if (state_q == StStop) begin
            wrap_cnt_q <= wraps_d;
         end
      end
   end

   assign wrap_cnt = wrap_cnt_q;
`else
   assign wrap_cnt = 8'd0;
`endif

   assign gnt     = gnt_q;
   assign busy    = (state_q != StIdle);
   assign done    = done_q;
   assign done_id = done_id_q;
   assign result  = result_q;
   assign aborted = aborted_q;

endmodule

// File: tb/tb_pulse_counter_sched.sv
// Scoreboard bench for pulse_counter_sched with a behavioural pulse counter attached.
module tb_pulse_counter_sched;

   localparam int N     = 4;
   localparam int LEN_W = 8;
   localparam int DW    = 8;
   localparam int MAX   = 20;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [N-1:0]      req = '0;
   logic [N*LEN_W-1:0] req_len = '0;
   logic              abort = 1'b0;
   logic [N-1:0]      gnt;
   logic              busy;
   logic              cnt_reset, cnt_start, cnt_stop;
   logic [DW-1:0]     cnt_count = '0;
   logic              done;
   logic [1:0]        done_id;
   logic [DW-1:0]     result;
   logic              aborted;
   logic [7:0]        wrap_cnt;
   logic              running = 1'b0;

   pulse_counter_sched #(
      .N(N), .LEN_W(LEN_W), .DATA_WIDTH(DW), .MAX(MAX)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_len(req_len), .abort(abort),
      .gnt(gnt), .busy(busy), .cnt_reset(cnt_reset), .cnt_start(cnt_start),
      .cnt_stop(cnt_stop), .cnt_count(cnt_count), .done(done), .done_id(done_id),
      .result(result), .aborted(aborted), .wrap_cnt(wrap_cnt)
   );

   always #5 clk = ~clk;

   // External counter: clear, start (counts on the start cycle), stop/hold, wrap MAX->0.
   always @(posedge clk) begin
      if (cnt_reset) begin
         cnt_count <= '0;
         running   <= 1'b0;
      end else if (cnt_stop) begin
         running <= 1'b0;
      end else if (cnt_start || running) begin
         running   <= 1'b1;
         cnt_count <= (cnt_count == DW'(MAX)) ? '0 : cnt_count + 1'b1;
      end
   end

   typedef struct {
      int id;
      int res;
      bit abt;
      int wraps;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   model_ptr = 0;
   int   lens[N];
   bit   mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d", name, act, expv);
      end
   endtask

   function automatic int model_pick(input logic [N-1:0] pat);
      for (int i = 0; i < N; i++) begin
         int c;
         c = (model_ptr + i) % N;
         if (pat[c]) begin
            model_ptr = (c + 1) % N;
            return c;
         end
      end
      return -1;
   endfunction

   function automatic exp_t model_window(input int id, input int len, input int abort_k);
      exp_t e;
      int   n;
      n       = (abort_k > 0) ? abort_k - 1 : len;
      e.id    = id;
      e.res   = n % (MAX + 1);
      e.abt   = (abort_k > 0);
`ifdef PULSE_COUNTER_SCHED_WRAP_COUNT_EN
      e.wraps = (n / (MAX + 1) > 255) ? 255 : n / (MAX + 1);
`else
      e.wraps = 0;
`endif
      return e;
   endfunction

   // Monitor: pops an expectation on every done pulse, plus counter-pin invariants.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en && !reset) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: got done_id %0d result %0d, required no done",
                        done_id, result);
            end else begin
               e = exp_q.pop_front();
               check("done_id", 64'(done_id), 64'(e.id));
               check("result", 64'(result), 64'(e.res));
               check("aborted", 64'(aborted), 64'(e.abt));
               check("wrap_cnt", 64'(wrap_cnt), 64'(e.wraps));
            end
         end
         check("counter_pins_exclusive",
               64'($countones({cnt_reset, cnt_start, cnt_stop}) <= 1), 64'(1));
         if (!busy) check("counter_pins_quiet_in_idle",
                          64'({cnt_reset, cnt_start, cnt_stop}), 64'(0));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_lens();
      for (int i = 0; i < N; i++) req_len[i*LEN_W +: LEN_W] = LEN_W'(lens[i]);
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, 64'({gnt, busy, cnt_reset, cnt_start, cnt_stop, done, done_id, result,
                       aborted, wrap_cnt}), 64'(0));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      abort = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check_reset_outputs("reset_outputs");
      model_ptr = 0;
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 1000) begin
         tick();
         n++;
      end
      if (busy) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout: got busy=1 after %0d cycles, required busy=0", n);
      end
   endtask

   // Issue one request pattern in an IDLE cycle and follow the granted window to its done.
   task automatic run_window(input logic [N-1:0] pat, input int abort_k, input bit abort_clr);
      int         win, len, run, cyc, gcyc, starts, lat;
      bit         stop_ab;
      logic [N-1:0] oh;
      win = model_pick(pat);
      len = lens[win];
      run = (abort_k > 0) ? abort_k : len;
      exp_q.push_back(model_window(win, len, abort_k));
      oh      = '0;
      oh[win] = 1'b1;
      req     = pat;
      drive_lens();
      cyc = 0; lat = -1; gcyc = 0; starts = 0; stop_ab = 1'b0;
      while (lat < 0 && cyc < 600) begin
         @(negedge clk);
         if (gnt == oh) gcyc++;
         if (cnt_start) starts++;
         if (abort_k > 0 && cyc == 1 + abort_k) stop_ab = cnt_stop;
         if (cyc > 0 && done) begin
            lat = cyc;
         end else begin
            tick();
            cyc++;
            // Random req/req_len while busy must be ignored; req returns to 0 before IDLE.
            req = (cyc >= 2 && cyc <= run + 1) ? N'($urandom) : '0;
            req_len = $urandom;
            abort = (abort_k > 0 && cyc == 1 + abort_k) || (abort_clr && cyc == 1);
         end
      end
      abort = 1'b0;
      req   = '0;
      if (lat < 0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout: got no done in %0d cycles, required done at %0d",
                  cyc, run + 3);
      end else begin
         check("done_latency", 64'(lat), 64'(run + 3));
         check("gnt_cycles", 64'(gcyc), 64'(run + 2));
         check("start_pulses", 64'(starts), 64'((len > 0 && abort_k != 1) ? 1 : 0));
         if (abort_k > 0) check("stop_on_abort", 64'(stop_ab), 64'(1));
      end
      tick();
   endtask

   initial begin
      int cyc, dones, pat, mode, k;
      lens = '{0, 0, 0, 0};
      do_reset();
      mon_en = 1'b1;

      lens[0] = 5;
      run_window(4'b0001, 0, 1'b0);
      wait_idle();
      lens[0] = 25;
      run_window(4'b0001, 0, 1'b0);
      wait_idle();

      // Four held requests served back to back, then the fifth grant wraps to 0.
      do_reset();
      lens = '{3, 4, 5, 6};
      for (int i = 0; i < 5; i++) begin
         int w;
         w = model_pick(4'b1111);
         exp_q.push_back(model_window(w, lens[w], 0));
      end
      req = 4'b1111;
      drive_lens();
      cyc = 0;
      dones = 0;
      while (dones < 4 && cyc < 200) begin
         @(negedge clk);
         if (done && cyc > 0) dones++;
         if (dones < 4) begin
            tick();
            cyc++;
         end
      end
      check("b2b_total_cycles", 64'(cyc), 64'(30));
      tick();
      req = '0;
      @(negedge clk);
      check("fifth_gnt", 64'(gnt), 64'(1));
      tick();
      wait_idle();

      lens[2] = 10;
      run_window(4'b0100, 4, 1'b0);
      wait_idle();
      lens[1] = 0;
      run_window(4'b0010, 0, 1'b0);
      wait_idle();

      // Reset in RUN cycle 2 of requester 3: the window vanishes without a done.
      lens[3] = 8;
      req = 4'b1000;
      drive_lens();
      tick();
      req = '0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid_window_reset_outputs");
      model_ptr = 0;
      tick();
      lens[0] = 2;
      run_window(4'b1001, 0, 1'b0);
      wait_idle();

      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < N; i++)
            lens[i] = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 70) : $urandom_range(0, 25);
         pat  = $urandom_range(1, 15);
         mode = $urandom_range(0, 3);
         // The winner is needed before issue to pick a legal abort cycle.
         begin
            int save, w;
            save = model_ptr;
            w = model_pick(N'(pat));
            model_ptr = save;
            k = (mode == 2 && lens[w] > 0) ? $urandom_range(1, lens[w]) : 0;
         end
         run_window(N'(pat), k, mode == 3);
         wait_idle();
      end

      repeat (5) tick();
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: got no finish by 90000 cycles, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pulse_counter_sched.md
Name: pulse_counter_sched

Overview:
- Round-robin scheduler that shares one pulse counter (start/stop/hold/wrap-at-MAX counter) between N requesters.
- Each requester asks for a measurement window of a given length. The scheduler grants one requester at a time, clears the counter, runs it for the window, stops it, then returns the captured count with the requester ID.
- Sits between the requesting blocks and the counter's reset/start/stop pins.

Parameters:
- N, 4, number of requesters (2..16).
- LEN_W, 8, width of each window-length field.
- DATA_WIDTH, 8, counter width; must match the counter instance.
- MAX, 20, counter wrap value; must match the counter instance.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N  request bits; sampled only in IDLE.
- req_len  in  N*LEN_W  window lengths; requester i uses bits [i*LEN_W +: LEN_W].
- abort  in  1  ends the active window early.
- gnt  out  N  one-hot grant; held from CLR through STOP.
- busy  out  1  high in any state other than IDLE.
- cnt_reset  out  1  drives counter reset.
- cnt_start  out  1  drives counter start.
- cnt_stop  out  1  drives counter stop.
- cnt_count  in  DATA_WIDTH  counter output.
- done  out  1  one-cycle pulse; result is valid.
- done_id  out  $clog2(N)  ID of the finished requester.
- result  out  DATA_WIDTH  captured count.
- aborted  out  1  qualifies done; the window was cut short.
- wrap_cnt  out  8  wrap count (see Optional Feature).

Behaviour:
- Reset: every output is 0; state is IDLE; the round-robin pointer selects requester 0 as highest priority. Reset mid-window discards the window and produces no done. Reset has priority over every other input.
- States and transitions:
  - IDLE: if any req is set, pick the first set bit searching from pointer upward, modulo N. Register gnt, latch that requester's length L, set pointer = granted+1 mod N, then go to CLR.
  - CLR: one cycle. Go to STOP if L==0, otherwise go to RUN.
  - RUN: exactly L cycles. Exit early to STOP on abort.
  - STOP: one cycle. At its edge, capture result <= cnt_count, set done_id, return to IDLE.
- Output decode (Moore, except abort):
  - cnt_reset = (state==CLR).
  - cnt_start = first RUN cycle only.
  - cnt_stop = (state==STOP) | (state==RUN & abort).
  - Exactly one of the three is high in any cycle, or none.
- Done handshake: done, result, done_id and aborted are registered. done is high in the first IDLE cycle after STOP. Arbitration in that same cycle is allowed, giving back-to-back windows with no gap.
- Timing: req seen in cycle T → gnt and busy from T+1 → CLR at T+1 → RUN at T+2..T+1+L → STOP at T+2+L → done at T+3+L.
- Expected result: L mod (MAX+1). The counter counts on the start cycle and wraps MAX→0.
- Abort in RUN cycle k (1-based): the counter stops at that edge, so result = (k-1) mod (MAX+1) and aborted=1. Abort outside RUN is ignored.
- Requester handshake:
  - Dropping req after grant does not cancel the window.
  - A requester holding req is re-granted only after every other pending requester has been served.
  - req and req_len changes during busy are ignored.
- The scheduler never drives counter signals in IDLE; the counter holds its last value.

Optional Feature:
- Macro: PULSE_COUNTER_SCHED_WRAP_COUNT_EN.
- When defined:
  - An 8-bit saturating counter clears in CLR.
  - It increments on each cycle in RUN/STOP where cnt_count < its previous-cycle value (a wrap).
  - wrap_cnt is registered alongside result at done.
- When undefined: wrap_cnt is tied to 0 and no wrap logic is synthesised.

Test Plan:
- Reset, then req=0001, len0=5 → gnt=0001 for 7 cycles; cnt_start one pulse; done with result=5, done_id=0, aborted=0, 8 cycles after req.
- req=0001, len0=25 → result=4 (25 mod 21); wrap_cnt=1 with macro, 0 without.
- After reset, req=1111 held, lens 3/4/5/6 → done_id sequence 0,1,2,3 with results 3,4,5,6; back-to-back windows with no idle gap; fifth grant goes to 0.
- req=0100, len2=10, abort in RUN cycle 4 → cnt_stop high that cycle; result=3, aborted=1, done_id=2.
- req=0010, len1=0 → CLR then STOP, no cnt_start; result=0, done_id=1.
- Reset asserted in RUN cycle 2 of a len=8 window for requester 3, then req=1001 → all outputs 0, no done; next grant goes to requester 0.
